ffe_equalizer: RTL and testbench

4-tap feed-forward equalizer (FIR) for a sampled receive path. Each sample presented with a load strobe shifts into a 4-deep delay line. The block computes the weighted sum of the delay line with fixed signed coefficients and emits one equalized sample per load, flagged by a one-cycle valid pulse.

---
 rtl/ffe_equalizer.sv | 82 ++++++++
 tb/tb_ffe_equalizer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ffe_equalizer.sv
// 4-tap feed-forward equalizer: delay line, registered products, and a
// registered floor-shifted, saturated sum with a valid pulse two cycles after each load.
module ffe_equalizer #(
  parameter int width = 12,
  parameter int FRAC  = 6,
  parameter int C0    = 64,
  parameter int C1    = -16,
  parameter int C2    = 8,
  parameter int C3    = -4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [width-1:0] ffe_in_data,
  input  logic                    load_sig,
  output logic signed [width-1:0] ffe_out_data,
  output logic                    ffe_out_valid
);

  localparam int PW = 2 * width;
  localparam int SW = 2 * width + 2;

  // Coefficients widened to product width so the multiply is done in full precision.
  localparam logic signed [PW-1:0] coef [4] = '{PW'(C0), PW'(C1), PW'(C2), PW'(C3)};

  localparam logic signed [SW-1:0] sat_max = {{(SW-width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [SW-1:0] sat_min = {{(SW-width+1){1'b1}}, {(width-1){1'b0}}};

  logic signed [width-1:0] x [4];
  logic signed [PW-1:0]    xe [4];
  logic signed [PW-1:0]    p [4];
  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    shifted;
  logic signed [width-1:0] sat_data;
  logic                    load_d;
  logic                    prod_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) x[i] <= '0;
    end else if (load_sig) begin
      x[0] <= ffe_in_data;
      for (int i = 1; i < 4; i++) x[i] <= x[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tap
      assign xe[gi] = {{width{x[gi][width-1]}}, x[gi]};

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) p[gi] <= '0;
        else      p[gi] <= coef[gi] * xe[gi];
      end
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) sum = sum + {{2{p[i][PW-1]}}, p[i]};
    shifted = sum >>> FRAC;
    sat_data = shifted[width-1:0];
    if (shifted > sat_max)      sat_data = {1'b0, {(width-1){1'b1}}};
    else if (shifted < sat_min) sat_data = {1'b1, {(width-1){1'b0}}};
  end

  // Valid follows load_sig through the same two register stages as the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_d        <= 1'b0;
      prod_valid    <= 1'b0;
      ffe_out_valid <= 1'b0;
      ffe_out_data  <= '0;
    end else begin
      load_d        <= load_sig;
      prod_valid    <= load_d;
      ffe_out_valid <= prod_valid;
      if (prod_valid) ffe_out_data <= sat_data;
    end
  end

endmodule

// File: tb/tb_ffe_equalizer.sv
// Directed bench for ffe_equalizer: default-coefficient instance plus an
// all-64 coefficient instance used for saturation.
module tb_ffe_equalizer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [11:0] in_data = '0;
  logic load = 1'b0;
  logic signed [11:0] out_data;
  logic out_valid;
  logic signed [11:0] sat_in = '0;
  logic sat_load = 1'b0;
  logic signed [11:0] sat_out;
  logic sat_valid;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ffe_equalizer dut (
    .clk(clk), .rst(rst), .ffe_in_data(in_data), .load_sig(load),
    .ffe_out_data(out_data), .ffe_out_valid(out_valid)
  );

  ffe_equalizer #(.C0(64), .C1(64), .C2(64), .C3(64)) dut_sat (
    .clk(clk), .rst(rst), .ffe_in_data(sat_in), .load_sig(sat_load),
    .ffe_out_data(sat_out), .ffe_out_valid(sat_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_data(input string tag, input logic signed [11:0] obs, input int exp);
    n_assert++;
    assert (int'(obs) === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %s: data %0d (expected %0d)", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One load followed by three idle cycles; valid must pulse only after the second edge.
  task automatic load_and_check(input string tag, input logic signed [11:0] d, input int exp);
    in_data = d;
    load = 1'b1;
    tick();
    load = 1'b0;
    in_data = 12'sd999;
    check_bit({tag, " valid+0"}, out_valid, 1'b0);
    tick();
    check_bit({tag, " valid+1"}, out_valid, 1'b0);
    tick();
    check_bit({tag, " valid+2"}, out_valid, 1'b1);
    check_data({tag, " data"}, out_data, exp);
    tick();
    check_bit({tag, " valid+3"}, out_valid, 1'b0);
    check_data({tag, " hold"}, out_data, exp);
  endtask

  task automatic sat_load_and_check(input string tag, input logic signed [11:0] d, input int exp);
    sat_in = d;
    sat_load = 1'b1;
    tick();
    sat_load = 1'b0;
    tick();
    tick();
    check_bit({tag, " valid"}, sat_valid, 1'b1);
    check_data({tag, " data"}, sat_out, exp);
    tick();
  endtask

  initial begin
    int ramp_in [4] = '{64, 128, 192, 256};
    int ramp_exp [4] = '{64, 112, 168, 220};

    // Reset state
    #1;
    check_data("reset data", out_data, 0);
    check_bit("reset valid", out_valid, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Ramp with gaps
    for (int i = 0; i < 4; i++)
      load_and_check($sformatf("ramp%0d", i), 12'(ramp_in[i]), ramp_exp[i]);

    // Idle hold: nothing moves for 10 cycles
    for (int i = 0; i < 10; i++) begin
      in_data = 12'(i * 37);
      tick();
      check_bit("idle valid", out_valid, 1'b0);
    end
    check_data("idle hold", out_data, 220);
    // Delay line held 256,192,128: 0 -> (-4096 + 1536 - 512) >> 6 = -48
    load_and_check("continue", 12'sd0, -48);

    // Mid-run reset clears output asynchronously and kills the in-flight load
    in_data = 12'sd64;
    load = 1'b1;
    tick();
    load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_data("async rst data", out_data, 0);
    check_bit("async rst valid", out_valid, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("no stale valid", out_valid, 1'b0);
    end

    // Floor toward -inf from a cleared delay line
    load_and_check("floor one", 12'sd1, 1);
    load_and_check("floor neg", 12'sd0, -1);

    // Back-to-back loads after a fresh reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_data = 12'(ramp_in[i]);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      if (i >= 2) begin
        check_bit($sformatf("b2b valid%0d", i), out_valid, 1'b1);
        check_data($sformatf("b2b data%0d", i - 2), out_data, ramp_exp[i-2]);
      end else begin
        check_bit($sformatf("b2b valid%0d", i), out_valid, 1'b0);
      end
    end
    tick();
    check_bit("b2b valid end", out_valid, 1'b0);
    check_data("b2b hold", out_data, 220);

    // Saturation with all coefficients at 1.0
    sat_load_and_check("sat p0", 12'sd2047, 2047);
    sat_load_and_check("sat p1", 12'sd2047, 2047);
    sat_load_and_check("sat p2", 12'sd2047, 2047);
    sat_load_and_check("sat p3", 12'sd2047, 2047);
    sat_load_and_check("sat n0", -12'sd2048, 2047);
    sat_load_and_check("sat n1", -12'sd2048, -2);
    sat_load_and_check("sat n2", -12'sd2048, -2048);
    sat_load_and_check("sat n3", -12'sd2048, -2048);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
